// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-side responder for the MEM pipeline stage.
//
// This block takes the MEM-stage latch contents and turns word loads and
// stores into req/ack bus transactions. The bus may insert any number of
// wait states. While an access is outstanding, the block stalls the
// pipeline. Each retired instruction produces a one-cycle registered
// writeback bundle. Misaligned, conflicting (load and store) and timed-out
// accesses raise a one-cycle error pulse.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   enable            MEM-stage instruction valid
//   load, store       word load / word store
//   write_reg         instruction writes the register file
//   reg_address       destination register
//   reg_data          ALU result, forwarded for non-memory instructions
//   mem_address       byte address of the access
//   mem_data          store data
//   bus_rdata/bus_ack read data and single-cycle completion from the bus
//   bus_req/bus_we    request (held until ack or abort) and write strobe
//   bus_addr/bus_wdata registered word address and write data
//   stall             combinational hold for the MEM latch and upstream
//   wb_*              registered writeback bundle, valid for one cycle
//   err_valid/err_code/err_addr  error pulse; code and address hold
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic        store,
  input  logic        write_reg,
  input  logic [4:0]  reg_address,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_data,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_write_reg,
  output logic [4:0]  wb_reg_address,
  output logic [31:0] wb_reg_data,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Last ACCESS cycle that may still wait for an ack.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             lat_write_reg;
  logic [4:0]       lat_reg_address;
  logic             memreq;
  logic             legal;

  always_comb begin
    memreq = enable & (load | store);
    legal  = (mem_address[1:0] == 2'b00) & ~(load & store);
    stall  = ((state == IDLE) & memreq & legal) | (state == ACCESS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      counter         <= '0;
      lat_write_reg   <= 1'b0;
      lat_reg_address <= '0;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
      wb_valid        <= 1'b0;
      wb_write_reg    <= 1'b0;
      wb_reg_address  <= '0;
      wb_reg_data     <= '0;
      err_valid       <= 1'b0;
      err_code        <= '0;
      err_addr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          wb_valid  <= 1'b0;
          err_valid <= 1'b0;
          if (enable) begin
            if (!(load | store)) begin
              // ALU result passes straight through to writeback.
              wb_valid       <= 1'b1;
              wb_write_reg   <= write_reg;
              wb_reg_address <= reg_address;
              wb_reg_data    <= reg_data;
            end else if (legal) begin
              state           <= ACCESS;
              counter         <= '0;
              bus_req         <= 1'b1;
              bus_we          <= store;
              bus_addr        <= {mem_address[31:2], 2'b00};
              bus_wdata       <= mem_data;
              lat_write_reg   <= write_reg;
              lat_reg_address <= reg_address;
            end else begin
              // Illegal access retires immediately, with no bus cycle.
              // A load/store conflict outranks misalignment.
              err_valid    <= 1'b1;
              err_addr     <= mem_address;
              err_code     <= (load & store) ? 2'b10 : 2'b01;
              wb_valid     <= 1'b1;
              wb_write_reg <= 1'b0;
            end
          end
        end

        ACCESS: begin
          // An ack in the final allowed cycle still beats the timeout.
          if (bus_ack) begin
            state          <= RESP;
            bus_req        <= 1'b0;
            wb_valid       <= 1'b1;
            wb_reg_address <= lat_reg_address;
            wb_write_reg   <= bus_we ? 1'b0 : lat_write_reg;
            wb_reg_data    <= bus_we ? 32'd0 : bus_rdata;
          end else if (counter == CNT_LAST) begin
            state        <= RESP;
            bus_req      <= 1'b0;
            err_valid    <= 1'b1;
            err_code     <= 2'b11;
            // A legal access is word aligned, so bus_addr equals mem_address.
            err_addr     <= bus_addr;
            wb_valid     <= 1'b1;
            wb_write_reg <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
          end
        end

        RESP: begin
          // The MEM latch advances at this edge. The inputs still show
          // the retiring instruction and must not be re-issued.
          state     <= IDLE;
          wb_valid  <= 1'b0;
          err_valid <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, load, store, write_reg;
  logic [4:0]  reg_address;
  logic [31:0] reg_data, mem_address, mem_data, bus_rdata;
  logic        bus_ack;
  logic        bus_req, bus_we, stall, wb_valid, wb_write_reg, err_valid;
  logic [31:0] bus_addr, bus_wdata, wb_reg_data, err_addr;
  logic [4:0]  wb_reg_address;
  logic [1:0]  err_code;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .store(store),
    .write_reg(write_reg), .reg_address(reg_address), .reg_data(reg_data),
    .mem_address(mem_address), .mem_data(mem_data), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .stall(stall), .wb_valid(wb_valid),
    .wb_write_reg(wb_write_reg), .wb_reg_address(wb_reg_address),
    .wb_reg_data(wb_reg_data), .err_valid(err_valid), .err_code(err_code),
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected DUT activity (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    int          cyc;
    logic        wr;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        chk_fields;
    logic        is_err;
    logic [1:0]  code;
    logic [31:0] eaddr;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  // Two independent views of memory: the model's, and the bus slave's.
  logic [31:0] ref_mem[int];
  logic [31:0] bus_mem[int];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a * 32'h9E3779B1;
  endfunction

  // Monitor: compares every writeback/error pulse against the scoreboard.
  logic [1:0]  last_code  = 2'b00;
  logic [31:0] last_eaddr = 32'h0;
  wb_exp_t     mon_e;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          flag("wb_unexpected");
        end else begin
          mon_e = wb_q.pop_front();
          chk("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("wb_write_reg", 32'(wb_write_reg), 32'(mon_e.wr));
          if (mon_e.chk_fields) begin
            chk("wb_reg_address", 32'(wb_reg_address), 32'(mon_e.ra));
            chk("wb_reg_data", wb_reg_data, mon_e.rd);
          end
          chk("err_valid", 32'(err_valid), 32'(mon_e.is_err));
          if (mon_e.is_err) begin
            last_code  = mon_e.code;
            last_eaddr = mon_e.eaddr;
          end
          chk("err_code", 32'(err_code), 32'(last_code));
          chk("err_addr", err_addr, last_eaddr);
        end
      end else if (err_valid) begin
        flag("err_without_wb");
      end
    end
  end

  // Bus slave: memory model with per-transaction wait states.
  logic     resp_en = 1'b1;
  logic     active  = 1'b0;
  bus_exp_t cur;
  int       wcnt;
  initial forever begin
    @(negedge clk);
    if (!resp_en || !reset) begin
      active = 1'b0;
    end else begin
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (!active && bus_req) begin
        if (bus_q.size() == 0) begin
          flag("bus_req_unexpected");
        end else begin
          cur    = bus_q.pop_front();
          active = 1'b1;
          wcnt   = 0;
          chk("bus_we", 32'(bus_we), 32'(cur.we));
          if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
        end
      end
      if (active) begin
        if (!bus_req) begin
          active = 1'b0;
        end else begin
          chk("bus_addr", bus_addr, cur.addr);
          if (wcnt == cur.wait_n) begin
            bus_ack = 1'b1;
            if (cur.we) bus_mem[int'(cur.addr[31:2])] = cur.wdata;
            else bus_rdata = bus_mem.exists(int'(cur.addr[31:2])) ?
                             bus_mem[int'(cur.addr[31:2])] : dflt(cur.addr);
            active = 1'b0;
          end
          wcnt++;
        end
      end
    end
  end

  // Presents one instruction at a negedge and holds it while stalled.
  // Returns at the negedge where the next instruction may be presented.
  task automatic issue(input logic en, input logic ld, input logic st, input logic wr,
                       input logic [4:0] ra, input logic [31:0] rd,
                       input logic [31:0] ma, input logic [31:0] md, input int wn);
    wb_exp_t  e;
    bus_exp_t b;
    logic     mreq, lgl;
    int       c, stalls, exp_stalls;
    enable = en; load = ld; store = st; write_reg = wr;
    reg_address = ra; reg_data = rd; mem_address = ma; mem_data = md;
    c    = cyc;
    mreq = en && (ld || st);
    lgl  = (ma[1:0] == 2'b00) && !(ld && st);
    e    = '{default: 0};
    exp_stalls = 0;
    if (en && !mreq) begin
      e.cyc = c + 1; e.wr = wr; e.ra = ra; e.rd = rd; e.chk_fields = 1'b1;
      wb_q.push_back(e);
    end else if (mreq && !lgl) begin
      e.cyc = c + 1; e.is_err = 1'b1; e.code = (ld && st) ? 2'b10 : 2'b01; e.eaddr = ma;
      wb_q.push_back(e);
    end else if (mreq) begin
      b.we = st; b.addr = ma; b.wdata = md; b.wait_n = wn;
      bus_q.push_back(b);
      if (wn < TIMEOUT) begin
        e.cyc = c + 2 + wn; e.ra = ra; e.chk_fields = 1'b1;
        if (ld) begin
          e.wr = wr;
          e.rd = ref_mem.exists(int'(ma[31:2])) ? ref_mem[int'(ma[31:2])] : dflt(ma);
        end else begin
          ref_mem[int'(ma[31:2])] = md;
        end
        exp_stalls = wn + 2;
      end else begin
        e.cyc = c + 1 + TIMEOUT; e.is_err = 1'b1; e.code = 2'b11; e.eaddr = ma;
        exp_stalls = TIMEOUT + 1;
      end
      wb_q.push_back(e);
    end
    #1;
    stalls = 0;
    for (int i = 0; i < 20 && stall; i++) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  logic       r_en, r_ld, r_st;
  logic [31:0] r_ma;
  int          kind;

  initial begin
    enable = 0; load = 0; store = 0; write_reg = 0; reg_address = 0;
    reg_data = 0; mem_address = 0; mem_data = 0; bus_ack = 0; bus_rdata = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_bus_we", 32'(bus_we), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_fields", {wb_reg_data[25:0], wb_reg_address, wb_write_reg}, 0);
    chk("rst_err", {err_addr[28:0], err_code, err_valid}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases.
    bus_mem[32'h100 >> 2] = 32'h12345678;
    ref_mem[32'h100 >> 2] = 32'h12345678;
    issue(1, 0, 0, 1, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 0);
    issue(1, 1, 0, 1, 5'd7, 32'h0, 32'h100, 32'h0, 3);
    issue(1, 0, 1, 1, 5'd9, 32'h0, 32'h204, 32'hA5A5A5A5, 0);
    issue(1, 1, 0, 1, 5'd4, 32'h0, 32'h102, 32'h0, 0);
    issue(1, 1, 1, 1, 5'd4, 32'h0, 32'h100, 32'h0, 0);
    issue(0, 1, 0, 1, 5'd4, 32'h0, 32'h100, 32'h0, 0);
    issue(1, 1, 0, 1, 5'd6, 32'h0, 32'h300, 32'h0, 10);
    issue(1, 1, 0, 1, 5'd8, 32'h0, 32'h204, 32'h0, TIMEOUT - 1);
    issue(1, 0, 0, 1, 5'd1, 32'h13572468, 32'h0, 32'h0, 0);

    // Reset in the middle of an access; the slave is silent here.
    resp_en = 1'b0;
    enable = 1; load = 1; store = 0; write_reg = 1; reg_address = 5'd3; mem_address = 32'h80;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_bus_req", 32'(bus_req), 1);
    enable = 0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 0);
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_wb_valid", 32'(wb_valid), 0);
    chk("midrst_err_code", 32'(err_code), 0);
    last_code = 2'b00; last_eaddr = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hBADBAD00;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("stray_ack_bus_req", 32'(bus_req), 0);
    chk("stray_ack_wb_valid", 32'(wb_valid), 0);
    @(negedge clk);
    resp_en = 1'b1;
    issue(1, 1, 0, 1, 5'd3, 32'h0, 32'h80, 32'h0, 1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r_en = ($urandom_range(0, 15) != 0);
      kind = $urandom_range(0, 9);
      r_ld = (kind >= 3 && kind <= 5) || kind == 9;
      r_st = (kind >= 6);
      r_ma = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) r_ma[1:0] = 2'($urandom_range(1, 3));
      issue(r_en, r_ld, r_st, 1'($urandom), 5'($urandom), $urandom, r_ma, $urandom,
            $urandom_range(0, 5));
    end

    enable = 0;
    repeat (4) @(negedge clk);
    chk("wb_q_drained", 32'(wb_q.size()), 0);
    chk("bus_q_drained", 32'(bus_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
